dual_pipe_stall_ctrl: RTL

- Central stall/flush controller for the two-pipeline global-stall datapath.
- Sits between the dual-stream producer (inputs: stall_1/stall_2; outputs: in_valid, flush_1/flush_2) and the two pipeline tails.
- Credit-tracks in-flight items per pipeline and generates each pipeline's stall.
- Round-robin arbitrates the two pipeline outputs onto one shared consumer port; sequences per-pipeline flush/drain.

---
 rtl/dual_pipe_stall_ctrl_if.sv | 31 +++
 rtl/dual_pipe_stall_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dual_pipe_stall_ctrl_if.sv
// Handshake bundle shared by the dual-stream producer, the two pipeline tails,
// the shared consumer port and the central stall/flush controller.
interface dual_pipe_stall_ctrl_if #(
  parameter int CW = 4
);
  logic [1:0]    in_valid;
  logic [1:0]    out_valid;
  logic          out_ready;
  logic          hold;
  logic [1:0]    flush_req;
  logic          stall_1;
  logic          stall_2;
  logic [1:0]    grant;
  logic          flush_1;
  logic          flush_2;
  logic [CW-1:0] occ_1;
  logic [CW-1:0] occ_2;
  logic          busy;

  // Environment side: producer, pipeline tails and consumer.
  modport master (
    output in_valid, out_valid, out_ready, hold, flush_req,
    input  stall_1, stall_2, grant, flush_1, flush_2, occ_1, occ_2, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, out_valid, out_ready, hold, flush_req,
    output stall_1, stall_2, grant, flush_1, flush_2, occ_1, occ_2, busy
  );
endinterface

// File: rtl/dual_pipe_stall_ctrl.sv
// Central stall/flush controller for two globally-stalled pipelines: per-pipe
// credit tracking, round-robin merge onto one consumer port, flush/drain sequencing.
module dual_pipe_stall_ctrl #(
  parameter int CREDITS = 8,
  parameter int DEPTH   = 4,
  parameter int CW      = 4
) (
  input logic                   clk,
  input logic                   reset,
  dual_pipe_stall_ctrl_if.slave bus
);

  localparam int DCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e         state_q [2];
  state_e         state_d [2];
  logic [CW-1:0]  occ_q   [2];
  logic [CW-1:0]  occ_d   [2];
  logic [DCW-1:0] drain_q [2];
  logic [DCW-1:0] drain_d [2];
  logic [1:0]     flush_q;
  logic [1:0]     flush_d;
  logic           rr_q;     // 0: pipe1 wins a tie, 1: pipe2 wins a tie
  logic           rr_d;

  logic [1:0]     eligible;
  logic [1:0]     grant;
  logic [1:0]     stall;

  // Arbitration: a pipe in FLUSH/DRAIN is invisible to the consumer, whatever
  // its tail claims. Grants are suppressed during reset so nothing is consumed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant    = 2'b00;
    rr_d     = rr_q;
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = bus.out_valid[i] && (state_q[i] == ST_IDLE);
    end
    if (bus.out_ready && !reset) begin
      unique case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
      if (grant[0]) begin
        rr_d = 1'b1;
      end else if (grant[1]) begin
        rr_d = 1'b0;
      end
    end
  end

  // Stall is purely combinational so the producer sees it in the same cycle.
  // The credit term includes this cycle's in_valid: an item accepted now is
  // already counted when deciding whether the next one may come.
  always_comb begin
    stall = 2'b00;
    for (int i = 0; i < 2; i++) begin
      stall[i] = reset
               | bus.hold
               | (state_q[i] != ST_IDLE)
               | bus.flush_req[i]
               | (({1'b0, occ_q[i]} + (CW+1)'(bus.in_valid[i])) >= (CW+1)'(CREDITS));
    end
  end

  // Per-pipe flush/drain sequencing and occupancy.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      occ_d[i]   = occ_q[i];
      drain_d[i] = drain_q[i];

      unique case (state_q[i])
        ST_IDLE: begin
          if (bus.flush_req[i]) begin
            // The item offered alongside the flush request is dropped.
            state_d[i] = ST_FLUSH;
            occ_d[i]   = occ_q[i] - CW'(grant[i]);
          end else begin
            occ_d[i]   = occ_q[i] + CW'(bus.in_valid[i]) - CW'(grant[i]);
          end
        end
        ST_FLUSH: begin
          state_d[i] = ST_DRAIN;
          occ_d[i]   = '0;
          drain_d[i] = DCW'(DEPTH - 1);
        end
        ST_DRAIN: begin
          if (drain_q[i] == '0) begin
            state_d[i] = ST_IDLE;
          end else begin
            drain_d[i] = drain_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          occ_d[i]   = '0;
        end
      endcase

      // A fresh request while flushing or draining starts the sequence over.
      if ((state_q[i] != ST_IDLE) && bus.flush_req[i]) begin
        state_d[i] = ST_FLUSH;
      end

      flush_d[i] = (state_d[i] == ST_FLUSH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        occ_q[i]   <= '0;
        drain_q[i] <= '0;
      end
      flush_q <= 2'b00;
      rr_q    <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        occ_q[i]   <= occ_d[i];
        drain_q[i] <= drain_d[i];
      end
      flush_q <= flush_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.stall_1 = stall[0];
  assign bus.stall_2 = stall[1];
  assign bus.grant   = grant;
  assign bus.flush_1 = flush_q[0];
  assign bus.flush_2 = flush_q[1];
  assign bus.occ_1   = occ_q[0];
  assign bus.occ_2   = occ_q[1];
  assign bus.busy    = (|occ_q[0]) | (|occ_q[1])
                     | (state_q[0] != ST_IDLE) | (state_q[1] != ST_IDLE);

endmodule
